lvt_bram_core: RTL and testbench

LVT_BRAM_CORE -- requirements
Module: lvt_bram

---
 rtl/lvt_bram_pkg.sv | 12 +
 rtl/lvt_bram_bank.sv | 32 +++
 rtl/lvt_bram_core.sv | 87 ++++++++
 tb/tb_lvt_bram_core.sv | 145 ++++++++++++++
 4 files changed

// File: rtl/lvt_bram_pkg.sv
// rtl/lvt_bram_pkg.sv - shared sizing defaults and port-select type for the LVT memory
package lvt_bram_pkg;
   localparam int LVT_ADDR_W = 7;
   localparam int LVT_DATA_W = 5;
   localparam int LVT_OUT_W  = 7;
   localparam int LVT_DEPTH  = 2 ** LVT_ADDR_W;

   typedef enum logic {
      PORT0 = 1'b0,
      PORT1 = 1'b1
   } port_sel_t;
endpackage

// File: rtl/lvt_bram_bank.sv
// rtl/lvt_bram_bank.sv - one write / one synchronous read RAM bank, no reset
module lvt_bram_bank
   import lvt_bram_pkg::*;
#(
   parameter int ADDR_W = LVT_ADDR_W,
   parameter int DATA_W = LVT_DATA_W
) (
   input  logic              i_clk,
   input  logic              i_wr_en,
   input  logic [ADDR_W-1:0] i_wr_addr,
   input  logic [DATA_W-1:0] i_wr_data,
   input  logic              i_rd_en,
   input  logic [ADDR_W-1:0] i_rd_addr,
   output logic [DATA_W-1:0] o_rd_data
);
   localparam int DEPTH = 2 ** ADDR_W;

   logic [DATA_W-1:0] r_mem [DEPTH];
   logic [DATA_W-1:0] r_rd_data;

   // Read-before-write: a same-address read returns the old word.
   always_ff @(posedge i_clk) begin
      if (i_wr_en) begin
         r_mem[i_wr_addr] <= i_wr_data;
      end
      if (i_rd_en) begin
         r_rd_data <= r_mem[i_rd_addr];
      end
   end

   assign o_rd_data = r_rd_data;
endmodule

// File: rtl/lvt_bram_core.sv
// rtl/lvt_bram_core.sv - 2-write/1-read memory built from two banks and a live-value table
module lvt_bram_core
   import lvt_bram_pkg::*;
#(
   parameter int ADDR_W = LVT_ADDR_W,
   parameter int DATA_W = LVT_DATA_W,
   parameter int OUT_W  = LVT_OUT_W
) (
   input  logic              i_clk,
   input  logic              i_rst_n,
   input  logic              i_wr0_en,
   input  logic [ADDR_W-1:0] i_wr0_addr,
   input  logic [DATA_W-1:0] i_wr0_data,
   input  logic              i_wr1_en,
   input  logic [ADDR_W-1:0] i_wr1_addr,
   input  logic [DATA_W-1:0] i_wr1_data,
   input  logic              i_rd0_en,
   input  logic [ADDR_W-1:0] i_rd0_addr,
   output logic [OUT_W-1:0]  o_rd0_data
);
   localparam int DEPTH = 2 ** ADDR_W;

   port_sel_t         r_lvt   [DEPTH];
   logic [DEPTH-1:0]  r_valid;
   port_sel_t         r_rd_sel;
   logic              r_rd_valid;

   logic              w_wr0_en;
   logic              w_wr1_en;
   logic              w_rd_en;
   logic [DATA_W-1:0] w_bank0_data;
   logic [DATA_W-1:0] w_bank1_data;
   logic [DATA_W-1:0] w_rd_data;

   assign w_wr0_en = i_wr0_en & i_rst_n;
   assign w_wr1_en = i_wr1_en & i_rst_n;
   assign w_rd_en  = i_rd0_en & i_rst_n;

   lvt_bram_bank #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) u_bank0 (
      .i_clk     (i_clk),
      .i_wr_en   (w_wr0_en),
      .i_wr_addr (i_wr0_addr),
      .i_wr_data (i_wr0_data),
      .i_rd_en   (w_rd_en),
      .i_rd_addr (i_rd0_addr),
      .o_rd_data (w_bank0_data)
   );

   lvt_bram_bank #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) u_bank1 (
      .i_clk     (i_clk),
      .i_wr_en   (w_wr1_en),
      .i_wr_addr (i_wr1_addr),
      .i_wr_data (i_wr1_data),
      .i_rd_en   (w_rd_en),
      .i_rd_addr (i_rd0_addr),
      .o_rd_data (w_bank1_data)
   );

   // Port 1 is applied after port 0 so it wins a same-address collision.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         for (int i = 0; i < DEPTH; i++) begin
            r_lvt[i] <= PORT0;
         end
         r_valid    <= '0;
         r_rd_sel   <= PORT0;
         r_rd_valid <= 1'b0;
      end else begin
         if (i_rd0_en) begin
            r_rd_sel   <= r_lvt[i_rd0_addr];
            r_rd_valid <= r_valid[i_rd0_addr];
         end
         if (i_wr0_en) begin
            r_lvt[i_wr0_addr]   <= PORT0;
            r_valid[i_wr0_addr] <= 1'b1;
         end
         if (i_wr1_en) begin
            r_lvt[i_wr1_addr]   <= PORT1;
            r_valid[i_wr1_addr] <= 1'b1;
         end
      end
   end

   assign w_rd_data  = !r_rd_valid        ? '0 :
                       (r_rd_sel == PORT1) ? w_bank1_data : w_bank0_data;
   assign o_rd0_data = OUT_W'(w_rd_data);
endmodule

// File: tb/tb_lvt_bram_core.sv
// tb/tb_lvt_bram_core.sv - directed vector bench for lvt_bram_core
module tb_lvt_bram_core;
   logic       clk = 1'b0;
   logic       rst_n;
   logic       wr0_en, wr1_en, rd0_en;
   logic [6:0] wr0_addr, wr1_addr, rd0_addr;
   logic [4:0] wr0_data, wr1_data;
   logic [6:0] rd0_data;

   int total = 0;
   int bad   = 0;

   typedef struct {
      logic       w0e;
      logic [6:0] w0a;
      logic [4:0] w0d;
      logic       w1e;
      logic [6:0] w1a;
      logic [4:0] w1d;
      logic       re;
      logic [6:0] ra;
      logic [6:0] exp;
   } vec_t;

   vec_t vecs[$];

   always #5 clk = ~clk;

   lvt_bram_core dut (
      .i_clk      (clk),
      .i_rst_n    (rst_n),
      .i_wr0_en   (wr0_en),
      .i_wr0_addr (wr0_addr),
      .i_wr0_data (wr0_data),
      .i_wr1_en   (wr1_en),
      .i_wr1_addr (wr1_addr),
      .i_wr1_data (wr1_data),
      .i_rd0_en   (rd0_en),
      .i_rd0_addr (rd0_addr),
      .o_rd0_data (rd0_data)
   );

   task automatic check(input string name, input logic [6:0] act, input logic [6:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   task automatic add(input logic w0e, input int w0a, input int w0d,
                      input logic w1e, input int w1a, input int w1d,
                      input logic re, input int ra, input int exp);
      vec_t v;
      v.w0e = w0e; v.w0a = 7'(w0a); v.w0d = 5'(w0d);
      v.w1e = w1e; v.w1a = 7'(w1a); v.w1d = 5'(w1d);
      v.re  = re;  v.ra  = 7'(ra);  v.exp = 7'(exp);
      vecs.push_back(v);
   endtask

   task automatic drive(input vec_t v);
      wr0_en = v.w0e; wr0_addr = v.w0a; wr0_data = v.w0d;
      wr1_en = v.w1e; wr1_addr = v.w1a; wr1_data = v.w1d;
      rd0_en = v.re;  rd0_addr = v.ra;
   endtask

   task automatic apply(input vec_t v, input string name);
      drive(v);
      @(posedge clk);
      #1;
      check(name, rd0_data, v.exp);
   endtask

   initial begin
      vec_t idle;
      vec_t v;
      idle = '{1'b0, 7'd0, 5'd0, 1'b0, 7'd0, 5'd0, 1'b0, 7'd0, 7'd0};
      drive(idle);
      rst_n = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      check("reset_state", rd0_data, 7'd0);
      rst_n = 1'b1;

      //   w0e w0a w0d  w1e w1a w1d  re ra  exp
      add(1, 10,  5,  0,  0,  0,  0,  0,  0);
      add(0,  0,  0,  0,  0,  0,  1, 10,  5);
      add(0,  0,  0,  1, 20, 10,  0,  0,  5);
      add(0,  0,  0,  0,  0,  0,  1, 20, 10);
      add(0,  0,  0,  0,  0,  0,  1,  5,  0);
      add(1, 50, 25,  0,  0,  0,  0,  0,  0);
      add(0,  0,  0,  1, 50, 30,  0,  0,  0);
      add(0,  0,  0,  0,  0,  0,  1, 50, 30);
      add(1, 50,  7,  0,  0,  0,  0,  0, 30);
      add(0,  0,  0,  0,  0,  0,  1, 50,  7);
      add(1, 70,  3,  1, 70,  9,  0,  0,  7);
      add(0,  0,  0,  0,  0,  0,  1, 70,  9);
      add(1, 90,  4,  1,100,  6,  0,  0,  9);
      add(0,  0,  0,  0,  0,  0,  1, 90,  4);
      add(0,  0,  0,  0,  0,  0,  1,100,  6);
      add(1, 70, 12,  0,  0,  0,  1, 70,  9);
      add(0,  0,  0,  0,  0,  0,  1, 70, 12);
      add(0,  0,  0,  0,  0,  0,  0, 10, 12);
      add(1,  0, 17,  1,127, 31,  1,127,  0);
      add(0,  0,  0,  0,  0,  0,  1,127, 31);
      add(0,  0,  0,  0,  0,  0,  1,  0, 17);
      add(0,  0,  0,  1, 10, 22,  1, 10,  5);
      add(0,  0,  0,  0,  0,  0,  1, 10, 22);
      add(1, 10,  2,  0,  0,  0,  0,  0, 22);
      add(0,  0,  0,  0,  0,  0,  1, 10,  2);

      foreach (vecs[i]) begin
         apply(vecs[i], $sformatf("vec[%0d]", i));
      end

      // Asynchronous clear mid-cycle, with traffic presented while held in reset.
      drive(idle);
      @(posedge clk);
      #3;
      rst_n = 1'b0;
      #1;
      check("async_clear", rd0_data, 7'd0);
      v = idle;
      v.w0e = 1'b1; v.w0a = 7'd10; v.w0d = 5'd9;
      v.re  = 1'b1; v.ra  = 7'd10;
      drive(v);
      @(posedge clk);
      #1;
      check("held_in_reset", rd0_data, 7'd0);
      #3;
      drive(idle);
      rst_n = 1'b1;

      v = idle; v.re = 1'b1; v.ra = 7'd10; v.exp = 7'd0; apply(v, "post_rst_rd10");
      v = idle; v.re = 1'b1; v.ra = 7'd50; v.exp = 7'd0; apply(v, "post_rst_rd50");
      v = idle; v.re = 1'b1; v.ra = 7'd70; v.exp = 7'd0; apply(v, "post_rst_rd70");
      v = idle; v.w0e = 1'b1; v.w0a = 7'd50; v.w0d = 5'd21; v.exp = 7'd0;
      apply(v, "post_rst_wr50");
      v = idle; v.re = 1'b1; v.ra = 7'd50; v.exp = 7'd21; apply(v, "post_rst_rd50_new");
      v = idle; v.re = 1'b0; v.ra = 7'd10; v.exp = 7'd21; apply(v, "post_rst_hold");

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
